// File: rtl/mips_register_file_pkg.sv
// Shared constants for the mini MIPS datapath: register file geometry and the
// hardwired zero register index.
package mips_register_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam logic [2:0] REG_ZERO = 3'd0;

endpackage : mips_register_file_pkg

// File: rtl/mips_register_file_if.sv
// Register file access bus: one write port and two combinational read ports.
// The datapath side is the master; the register file is the slave.
interface mips_register_file_if
    import mips_register_file_pkg::*;
#(
    parameter int DATA_W = mips_register_file_pkg::DATA_W,
    parameter int ADDR_W = mips_register_file_pkg::ADDR_W
);

    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2,
        input  read_data1, read_data2
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2,
        output read_data1, read_data2
    );

endinterface : mips_register_file_if

// File: rtl/mips_register_file_reg32_en.sv
// DATA_W-bit storage register with asynchronous active-high clear and a
// synchronous load enable.
module reg32_en
    import mips_register_file_pkg::*;
#(
    parameter int DATA_W = mips_register_file_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_r;

    // Storage: clear wins over everything, otherwise load when enabled.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_r <= '0;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule : reg32_en

// File: rtl/mips_register_file.sv
// Eight-entry register file with hardwired-zero register 0 and a same-cycle
// write-to-read bypass on both read ports.
module mips_register_file
    import mips_register_file_pkg::*;
#(
    parameter int DATA_W   = mips_register_file_pkg::DATA_W,
    parameter int ADDR_W   = mips_register_file_pkg::ADDR_W,
    parameter int NUM_REGS = mips_register_file_pkg::NUM_REGS
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_register_file_if.slave  bus
);

    logic [NUM_REGS-1:0] we_s;
    logic [DATA_W-1:0]   regs_s [NUM_REGS];
    logic [DATA_W-1:0]   rd1_s;
    logic [DATA_W-1:0]   rd2_s;

    // Priority: reset force, zero register, bypass, then stored value.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic              rst_i,
        input logic [ADDR_W-1:0] idx,
        input logic              wen,
        input logic [ADDR_W-1:0] widx,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (rst_i) begin
            v = '0;
        end else if (idx == ADDR_W'(REG_ZERO)) begin
            v = '0;
        end else if (wen && (widx == idx)) begin
            v = wdata;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // One-hot write decode gated by reg_write; bit 0 never enables anything.
    always_comb begin
        we_s = '0;
        if (bus.reg_write && !reset) begin
            we_s[bus.write_reg] = 1'b1;
        end else begin
            we_s = '0;
        end
        we_s[0] = 1'b0;
    end

    assign regs_s[0] = '0;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        reg32_en #(.DATA_W(DATA_W)) u_reg (
            .clk (clk),
            .clr (reset),
            .en  (we_s[gi]),
            .d   (bus.write_data),
            .q   (regs_s[gi])
        );
    end

    // Read port 1: index mux, bypass mux, zero/reset force.
    always_comb begin
        rd1_s = '0;
        rd1_s = read_sel(reset, bus.read_reg1, bus.reg_write, bus.write_reg,
                         bus.write_data, regs_s[bus.read_reg1]);
    end

    // Read port 2: same structure as port 1, fully independent.
    always_comb begin
        rd2_s = '0;
        rd2_s = read_sel(reset, bus.read_reg2, bus.reg_write, bus.write_reg,
                         bus.write_data, regs_s[bus.read_reg2]);
    end

    assign bus.read_data1 = rd1_s;
    assign bus.read_data2 = rd2_s;

endmodule : mips_register_file

// File: tb/tb_mips_register_file.sv
// Directed and randomized bench for mips_register_file against an array-based
// model of the architectural register state.
module tb_mips_register_file;
    import mips_register_file_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] model [8];

    mips_register_file_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    mips_register_file #(.DATA_W(32), .ADDR_W(3), .NUM_REGS(8)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expect_rd(input logic [2:0] idx);
        if (rst) return 32'd0;
        if (idx == 3'd0) return 32'd0;
        if (bus.reg_write && bus.write_reg == idx) return bus.write_data;
        return model[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wr, input logic [31:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2);
        bus.reg_write  = we;
        bus.write_reg  = wr;
        bus.write_data = wd;
        bus.read_reg1  = r1;
        bus.read_reg2  = r2;
        #1;
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_p1"}, bus.read_data1, expect_rd(bus.read_reg1));
        check({tag, "_p2"}, bus.read_data2, expect_rd(bus.read_reg2));
    endtask

    // Advance one rising edge, updating the model, and return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (bus.reg_write && !rst && bus.write_reg != 3'd0)
            model[bus.write_reg] = bus.write_data;
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 32'd0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clear_model();
        rst = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd0);
        @(negedge clk);
        drive(1'b1, 3'd5, 32'hFFFF_FFFF, 3'd5, 3'd5);
        check("reset_p1", bus.read_data1, 32'd0);
        check("reset_p2", bus.read_data2, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd1);
        check("post_reset_r5", bus.read_data1, 32'd0);

        // Reset between edges clears a written register.
        drive(1'b1, 3'd5, 32'hDEAD_BEEF, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd5);
        check("r5_written", bus.read_data1, 32'hDEAD_BEEF);
        rst = 1'b1;
        clear_model();
        #1;
        check("r5_in_reset", bus.read_data1, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("r5_after_reset", bus.read_data1, 32'd0);
        tick();

        // Basic write/read.
        drive(1'b1, 3'd1, 32'h0000_0011, 3'd0, 3'd0);
        tick();
        drive(1'b1, 3'd2, 32'hFFFF_FFFE, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd1, 3'd2);
        check("basic_r1", bus.read_data1, 32'h0000_0011);
        check("basic_r2", bus.read_data2, 32'hFFFF_FFFE);
        check("basic_add", bus.read_data1 + bus.read_data2, 32'h0000_000F);

        // Writes to register 0 are discarded.
        drive(1'b1, 3'd0, 32'h1234_5678, 3'd0, 3'd0);
        check("r0_same_p1", bus.read_data1, 32'd0);
        check("r0_same_p2", bus.read_data2, 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
        check("r0_later_p1", bus.read_data1, 32'd0);
        check("r0_later_p2", bus.read_data2, 32'd0);

        // Bypass on both ports, then storage.
        drive(1'b1, 3'd3, 32'hAAAA_AAAA, 3'd0, 3'd0);
        tick();
        drive(1'b1, 3'd3, 32'h5555_5555, 3'd3, 3'd3);
        check("bypass_p1", bus.read_data1, 32'h5555_5555);
        check("bypass_p2", bus.read_data2, 32'h5555_5555);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd3);
        check("bypass_stored", bus.read_data1, 32'h5555_5555);

        // Write disable holds register 4.
        drive(1'b1, 3'd4, 32'h0000_0007, 3'd0, 3'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd4, 32'hCAFE_BABE, 3'd4, 3'd4);
            check("wdis_p1", bus.read_data1, 32'h0000_0007);
            check("wdis_p2", bus.read_data2, 32'h0000_0007);
            tick();
        end

        // Reset coincident with a writing edge loses the write.
        drive(1'b1, 3'd6, 32'h0000_0001, 3'd6, 3'd6);
        @(posedge clk);
        rst = 1'b1;
        clear_model();
        #2;
        check("edge_rst_in", bus.read_data1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 3'd6, 3'd3);
        check("edge_rst_r6", bus.read_data1, 32'd0);
        check("edge_rst_r3", bus.read_data2, 32'd0);
        drive(1'b1, 3'd6, 32'h0000_0002, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd6, 3'd6);
        check("edge_rst_r6_w2", bus.read_data1, 32'h0000_0002);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            check_ports("rand");
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                clear_model();
                #1;
                check_ports("rand_rst");
                rst = 1'b0;
                #1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mips_register_file
